// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Steps o_pos through the enabled digits, one slot of CLK_DIV cycles each.
// Every slot begins with BLANK_CYC forced-blank cycles to suppress ghosting,
// followed by a lit window whose length is set by the 4-bit brightness.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | scanning stopped (disabled or empty mask), segments off
// S_BLANK | cnt 0..BLANK_CYC-1 of a slot, digit switched, segments off
// S_ON    | lit window of the slot, segments driven
// S_OFF   | remainder of the slot after the lit window, segments off
module segment_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8,
  parameter int DIM_STEP  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_restart,
  input  logic [7:0] i_digit_mask,
  input  logic [3:0] i_brightness,
  output logic [2:0] o_pos,
  output logic       o_blank,
  output logic       o_frame_tick
);

  localparam logic [15:0] SLOT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
  localparam logic [15:0] DIM_STEP_W = 16'(DIM_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2,
    S_OFF   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  pos_q, pos_d;
  logic        blank_q, blank_d;
  logic        tick_q, tick_d;
  // Slot count of the last lit cycle, latched when the lit window opens so
  // brightness changes mid-slot cannot stretch or cut the current window.
  logic [15:0] on_last_q, on_last_d;

  logic [15:0] dim_off;
  logic [2:0]  pos_low;
  logic [2:0]  pos_next;
  logic        mask_any;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_bit = 3'(k);
    end
  endfunction

  // Lowest set bit strictly above p, wrapping to the lowest set bit overall.
  function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] p);
    logic found;
    found    = 1'b0;
    next_bit = lowest_bit(m);
    for (int k = 0; k < 8; k++) begin
      if (!found && m[k] && (3'(k) > p)) begin
        next_bit = 3'(k);
        found    = 1'b1;
      end
    end
  endfunction

  // Digit selection and lit-window arithmetic derived from the live inputs.
  always_comb begin
    dim_off  = 16'(4'd15 - i_brightness) * DIM_STEP_W;
    pos_low  = lowest_bit(i_digit_mask);
    pos_next = next_bit(i_digit_mask, pos_q);
    mask_any = |i_digit_mask;
  end

  // Next-state logic: enable beats restart, restart/idle-start beats slot end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    pos_d     = pos_q;
    tick_d    = 1'b0;
    on_last_d = on_last_q;

    if (!i_en) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
    end else if (i_restart || (state_q == S_IDLE)) begin
      cnt_d = 16'd0;
      if (mask_any) begin
        state_d = S_BLANK;
        pos_d   = pos_low;
        tick_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else if (cnt_q == SLOT_LAST) begin
      cnt_d = 16'd0;
      if (mask_any) begin
        state_d = S_BLANK;
        pos_d   = pos_next;
        tick_d  = (pos_next <= pos_q);
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d   = S_ON;
            on_last_d = SLOT_LAST - dim_off;
          end
        end
        S_ON: begin
          if (cnt_q == on_last_q) state_d = S_OFF;
        end
        default: ;
      endcase
    end

    blank_d = (state_d != S_ON);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      pos_q     <= 3'd0;
      blank_q   <= 1'b1;
      tick_q    <= 1'b0;
      on_last_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      blank_q   <= blank_d;
      tick_q    <= tick_d;
      on_last_q <= on_last_d;
    end
  end

  assign o_pos        = pos_q;
  assign o_blank      = blank_q;
  assign o_frame_tick = tick_q;

endmodule
